// File: rtl/uart_send.sv
// ---------------------------------------------------------------------------
// uart_send -- byte-wide UART transmitter (8N1, optional even parity)
//
// Serialises one byte per accepted request into a frame made of a start bit,
// eight data bits LSB first and a stop bit, each bit lasting BIT_CNT_MAX
// system clocks (BIT_CNT_MAX = CLK_FEQ / UART_BOT, legal range 2..65535).
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (frame grows from 10 to 11 bit
// periods). Without the macro the parity state and its logic do not exist.
//
// Parameters:
//   CLK_FEQ    system clock frequency in Hz
//   UART_BOT   baud rate in bit/s
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst    in   asynchronous active-low reset
//   send_en    in   transmit request, honoured only while tx_busy is low
//   send_data  in   byte to send, captured on the accepting edge
//   uart_tx    out  serial line, driven straight from a flop, idles high
//   tx_busy    out  high while a frame is in progress (requests dropped)
//   tx_done    out  one-cycle pulse in the final cycle of the stop bit
// ---------------------------------------------------------------------------
`default_nettype none

module uart_send #(
   parameter int CLK_FEQ  = 50_000_000,
   parameter int UART_BOT = 9600
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       send_en,
   input  logic [7:0] send_data,
   output logic       uart_tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int         BIT_CNT_MAX = CLK_FEQ / UART_BOT;
   localparam logic [15:0] BAUD_LAST  = 16'(BIT_CNT_MAX - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;
`endif

   state_t      state_q,    state_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_idx_q,  bit_idx_d;
   logic [7:0]  data_q,     data_d;
   logic        uart_tx_q,  uart_tx_d;

   logic baud_wrap;
   logic accept;

   // The bit-period counter reaching its last value marks the final cycle of
   // whatever bit is currently on the line.
   assign baud_wrap = (baud_cnt_q == BAUD_LAST);

   // tx_done / tx_busy are pure decodes of registered state, so they change
   // only right after a clock edge. The last stop-bit cycle already reports
   // "not busy", which is what lets a request on that edge chain frames.
   assign tx_done = (state_q == STOP) && baud_wrap;
   assign tx_busy = (state_q != IDLE) && !tx_done;
   assign accept  = send_en && !tx_busy;

   assign uart_tx = uart_tx_q;

   // ------------------------------------------------------------------------
   // Next-state and next-output logic. uart_tx_d is the value the line will
   // carry after the coming edge, so the pin is a plain flop output with no
   // combinational path from send_en.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; that is what keeps this block free of inferred latches.
      state_d    = state_q;
      baud_cnt_d = baud_wrap ? 16'd0 : baud_cnt_q + 16'd1;
      bit_idx_d  = bit_idx_q;
      data_d     = data_q;
      uart_tx_d  = uart_tx_q;

      unique case (state_q)
         IDLE: begin
            baud_cnt_d = 16'd0;
            uart_tx_d  = 1'b1;
            if (accept) begin
               data_d    = send_data;
               state_d   = START;
               uart_tx_d = 1'b0;
            end
         end

         START: begin
            if (baud_wrap) begin
               state_d   = DATA;
               bit_idx_d = 3'd0;
               uart_tx_d = data_q[0];
            end
         end

         DATA: begin
            if (baud_wrap) begin
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d   = PARITY;
                  uart_tx_d = ^data_q;
`else
                  state_d   = STOP;
                  uart_tx_d = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  uart_tx_d = data_q[bit_idx_q + 3'd1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_wrap) begin
               state_d   = STOP;
               uart_tx_d = 1'b1;
            end
         end
`endif

         STOP: begin
            if (baud_wrap) begin
               // A request seen on the closing edge of the stop bit starts
               // the next frame directly, with no idle cycle in between.
               if (accept) begin
                  data_d    = send_data;
                  state_d   = START;
                  uart_tx_d = 1'b0;
               end else begin
                  state_d   = IDLE;
                  uart_tx_d = 1'b1;
               end
            end
         end

         default: begin
            state_d    = IDLE;
            baud_cnt_d = 16'd0;
            uart_tx_d  = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers. An asynchronous reset abandons any frame in flight and
   // returns the line to idle-high immediately.
   // ------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         // NOTE: the hold register is a handful of flops, not a memory, so it
         // is reset along with everything else to keep post-reset state known.
         state_q    <= IDLE;
         baud_cnt_q <= 16'd0;
         bit_idx_q  <= 3'd0;
         data_q     <= 8'd0;
         uart_tx_q  <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // pre-edge values computed above, independent of statement order.
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         data_q     <= data_d;
         uart_tx_q  <= uart_tx_d;
      end
   end

endmodule

`default_nettype wire

// File: doc/uart_send.md
# uart_send

Byte-wide UART transmitter: serialises one 8-bit word per request into an 8N1 frame (start bit, 8 data bits LSB first, stop bit) at a fixed baud rate derived from the system clock. It is the transmit half of the UART link in the system. It feeds the board TX pin and accepts bytes from a loopback path or a command/response engine through a single-cycle request handshake.

## Interface
- `CLK_FEQ`, default 50_000_000: system clock frequency in Hz.
- `UART_BOT`, default 9600: baud rate in bit/s. `BIT_CNT_MAX = CLK_FEQ / UART_BOT` (integer division) is the number of clock cycles per bit. It must satisfy 2 ≤ `BIT_CNT_MAX` ≤ 65535.
- `sys_clk`, input, 1: system clock, rising-edge.
- `sys_rst`, input, 1: reset, asynchronous, active-low.
- `send_en`, input, 1: transmit request; sampled on every rising edge.
- `send_data`, input, 8: byte to send; captured on the edge where the request is accepted.
- `uart_tx`, output, 1: serial line. Registered output; idles high.
- `tx_busy`, output, 1: high while a frame is in progress and requests are ignored.
- `tx_done`, output, 1: one-cycle pulse in the final cycle of the stop bit.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PARITY (present only with the macro, see Configuration)
  - STOP
- Internal counters:
  - 16-bit bit-period counter `baud_cnt`, counting 0 … `BIT_CNT_MAX`−1.
  - 3-bit data index `bit_idx`, counting 0 … 7.
  - 8-bit shift/hold register.
- IDLE:
  - `uart_tx` = 1 and `tx_busy` = 0.
  - When `send_en` = 1, latch `send_data`, clear `baud_cnt`, and go to START.
- START: `uart_tx` = 0 for `BIT_CNT_MAX` cycles, then go to DATA with `bit_idx` = 0.
- DATA:
  - `uart_tx` = hold register bit `bit_idx`, held for `BIT_CNT_MAX` cycles per bit.
  - `bit_idx` increments when `baud_cnt` wraps.
  - After bit 7, go to STOP (or PARITY when configured).
- STOP:
  - `uart_tx` = 1 for `BIT_CNT_MAX` cycles.
  - In the last of those cycles, `tx_done` = 1 and `tx_busy` = 0.
  - The next state is IDLE, or START directly if `send_en` is sampled high at the end of that cycle.
- `baud_cnt` wraps to 0 when it reaches `BIT_CNT_MAX`−1. It is held at 0 in IDLE.
- Request handling:
  - `send_en` is honoured only when `tx_busy` = 0.
  - Requests while busy are dropped; there is no queueing and no error flag.
  - `send_data` may change freely after acceptance.
  - `send_en` held high continuously produces back-to-back frames with no idle gap. Each frame sends the `send_data` value present on its acceptance edge.
- Reset (asynchronous, including mid-frame): state IDLE, all counters 0, hold register 0, `uart_tx` = 1, `tx_busy` = 0, `tx_done` = 0. A truncated frame is not resumed.

## Timing
- Let E0 be the edge where `send_en` is accepted and B = `BIT_CNT_MAX`.
- `uart_tx` falls immediately after E0; the latency from request to start bit is 1 cycle.
- Bit k (start = 0, data = 1…8, stop = 9) is driven from after E0+kB through E0+(k+1)B−1.
- `tx_busy` is high from after E0 through E0+10B−2.
- `tx_busy` is low and `tx_done` is high in the cycle following E0+10B−1.
- A request at edge E0+10B starts the next start bit with zero idle cycles between frames.
- Frame length is 10B cycles, or 11B cycles with parity.
- `uart_tx` is driven straight from a flop: no glitches, and no combinational path from `send_en`.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - The PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for B cycles.
  - Frame = 11B cycles; `tx_done` moves to cycle E0+11B.
- Undefined: the PARITY state and its logic are absent; frames are 8N1 at 10B cycles.

## Test plan
- **Single byte.** CLK_FEQ = 50 MHz, UART_BOT = 9600 (B = 5208); `send_en` pulse with 0x55.
  - `uart_tx` = 0,1,0,1,0,1,0,1,0,1, each bit exactly 5208 cycles.
  - `tx_done` pulses once, at E0+52080.
  - `tx_busy` is high for 52079 cycles.
- **Back-to-back.** B = 4 for speed; send 0xA3, then assert `send_en` with 0x3C on the `tx_done` cycle.
  - The second start bit begins at E0+40 with no high gap.
  - Decoded bytes are 0xA3 then 0x3C.
- **Request while busy.** B = 4; send 0x0F, then pulse `send_en` with 0xFF at E0+12.
  - Only 0x0F is transmitted.
  - The line stays high after `tx_done`.
- **Reset mid-frame.** B = 4; send 0x00 and drop `sys_rst` at E0+20.
  - `uart_tx` goes to 1 immediately, `tx_busy` = 0, `tx_done` = 0.
  - After release, a new send of 0x81 is framed correctly.
- **Parity build.** `UART_TX_PARITY_EN`, B = 4.
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - `tx_done` is at E0+44.
